// File: rtl/led_matrix_scan.sv
// Row-scanning driver for the 16x16 red/green LED matrix board.
// Snapshots a frame at the frame boundary, shifts each row out serially,
// latches it and holds the row enabled for DWELL cycles.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   RedPixels    red frame [row][col]
//   GrnPixels    green frame [row][col]
//   frame_valid  pulse: a new frame is stable on the pixel inputs
//   ser_red      serial red column data
//   ser_grn      serial green column data
//   ser_clk      column shift clock (drivers sample on rising edge)
//   ser_latch    one-cycle pulse transferring the shifted row
//   row_en       one-hot row enable, zero while blanked
//   frame_done   one-cycle pulse at the end of the row 15 dwell
module led_matrix_scan #(
    parameter int unsigned DWELL = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0][15:0] RedPixels,
    input  logic [15:0][15:0] GrnPixels,
    input  logic              frame_valid,
    output logic              ser_red,
    output logic              ser_grn,
    output logic              ser_clk,
    output logic              ser_latch,
    output logic [15:0]       row_en,
    output logic              frame_done
);

    localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);

    typedef enum logic [1:0] {
        S_FRAME,
        S_SHIFT,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t            state_q;
    logic [3:0]        row_q;
    logic [4:0]        bit_q;
    logic [15:0]       dwell_q;
    logic              pending_q;
    logic [15:0][15:0] shadow_red_q;
    logic [15:0][15:0] shadow_grn_q;

    logic              ser_red_q;
    logic              ser_grn_q;
    logic              ser_clk_q;
    logic              ser_latch_q;
    logic [15:0]       row_en_q;
    logic              frame_done_q;

    // Column 15 goes out first; each column occupies two cycles.
    logic [3:0]        col;
    assign col = 4'd15 - bit_q[4:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FRAME;
            row_q        <= '0;
            bit_q        <= '0;
            dwell_q      <= '0;
            pending_q    <= 1'b1;
            shadow_red_q <= '0;
            shadow_grn_q <= '0;
            ser_red_q    <= 1'b0;
            ser_grn_q    <= 1'b0;
            ser_clk_q    <= 1'b0;
            ser_latch_q  <= 1'b0;
            row_en_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            ser_red_q    <= 1'b0;
            ser_grn_q    <= 1'b0;
            ser_clk_q    <= 1'b0;
            ser_latch_q  <= 1'b0;
            row_en_q     <= '0;
            frame_done_q <= 1'b0;

            // A capture in FRAME overrides this set below.
            if (frame_valid) begin
                pending_q <= 1'b1;
            end

            unique case (state_q)
                S_FRAME: begin
                    if (pending_q || frame_valid) begin
                        shadow_red_q <= RedPixels;
                        shadow_grn_q <= GrnPixels;
                        pending_q    <= 1'b0;
                    end
                    row_q   <= '0;
                    bit_q   <= '0;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    ser_red_q <= shadow_red_q[row_q][col];
                    ser_grn_q <= shadow_grn_q[row_q][col];
                    ser_clk_q <= bit_q[0];
                    bit_q     <= bit_q + 5'd1;
                    if (bit_q == 5'd31) begin
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    ser_latch_q <= 1'b1;
                    dwell_q     <= DWELL_M1;
                    state_q     <= S_DISPLAY;
                end
                S_DISPLAY: begin
                    row_en_q <= 16'(1) << row_q;
                    if (dwell_q == 16'd0) begin
                        if (row_q == 4'd15) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_FRAME;
                        end else begin
                            row_q   <= row_q + 4'd1;
                            bit_q   <= '0;
                            state_q <= S_SHIFT;
                        end
                    end else begin
                        dwell_q <= dwell_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_FRAME;
                end
            endcase
        end
    end

    assign ser_red    = ser_red_q;
    assign ser_grn    = ser_grn_q;
    assign ser_clk    = ser_clk_q;
    assign ser_latch  = ser_latch_q;
    assign row_en     = row_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Testbench for led_matrix_scan with DWELL = 4.
// Outputs are checked every cycle against a frame-timeline model.
module tb_led_matrix_scan;

    localparam int DW = 4;
    localparam int RP = 33 + DW;
    localparam int FP = 1 + 16 * RP;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;
    logic              frame_valid;
    logic              ser_red;
    logic              ser_grn;
    logic              ser_clk;
    logic              ser_latch;
    logic [15:0]       row_en;
    logic              frame_done;

    always #5 clk = ~clk;

    led_matrix_scan #(.DWELL(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .RedPixels   (RedPixels),
        .GrnPixels   (GrnPixels),
        .frame_valid (frame_valid),
        .ser_red     (ser_red),
        .ser_grn     (ser_grn),
        .ser_clk     (ser_clk),
        .ser_latch   (ser_latch),
        .row_en      (row_en),
        .frame_done  (frame_done)
    );

    wire [20:0] dut_out = {ser_red, ser_grn, ser_clk, ser_latch,
                           row_en, frame_done};

    int nvec = 0;
    int nerr = 0;

    // Model: position within the frame timeline plus the captured frame.
    int                m_t;
    logic              m_pend;
    logic [15:0][15:0] m_red;
    logic [15:0][15:0] m_grn;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs produced by the cycle at frame offset t.
    function automatic logic [20:0] model_out(input int t);
        logic [20:0] o;
        int u, r, p;
        o = '0;
        if (t != 0) begin
            u = t - 1;
            r = u / RP;
            p = u % RP;
            if (p < 32) begin
                o[20] = m_red[r][15 - p / 2];
                o[19] = m_grn[r][15 - p / 2];
                o[18] = (p % 2) == 1;
            end else if (p == 32) begin
                o[17] = 1'b1;
            end else begin
                o[16:1] = 16'(1) << r;
                o[0]    = (r == 15) && (p == RP - 1);
            end
        end
        return o;
    endfunction

    task automatic step(input string tag);
        logic [20:0] e;
        if (reset) begin
            e      = '0;
            m_t    = 0;
            m_pend = 1'b1;
            m_red  = '0;
            m_grn  = '0;
        end else begin
            e = model_out(m_t);
            if (m_t == 0) begin
                if (m_pend || frame_valid) begin
                    m_red  = RedPixels;
                    m_grn  = GrnPixels;
                    m_pend = 1'b0;
                end
            end else if (frame_valid) begin
                m_pend = 1'b1;
            end
            m_t = (m_t + 1) % FP;
        end
        @(posedge clk);
        #1;
        chk(tag, 32'(dut_out), 32'(e));
        if (ser_clk) begin
            chk("blank_on_sclk", 32'(row_en), 32'd0);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(tag);
        end
    endtask

    task automatic run_to(input int t, input string tag);
        for (int i = 0; i < FP && m_t != t; i++) begin
            step(tag);
        end
    endtask

    task automatic pulse_fv(input string tag);
        frame_valid = 1'b1;
        step(tag);
        frame_valid = 1'b0;
    endtask

    initial begin
        int latch_at, en1_cnt, fd_cnt, fd_at;
        logic [15:0] row0_bits;

        reset       = 1'b1;
        frame_valid = 1'b0;
        RedPixels   = '0;
        GrnPixels   = '0;
        m_t         = 0;
        m_pend      = 1'b1;
        m_red       = '0;
        m_grn       = '0;

        // 1: reset, release, first frame of zeros
        run(3, "reset");
        reset    = 1'b0;
        latch_at = 0;
        en1_cnt  = 0;
        for (int i = 1; i <= FP; i++) begin
            step("t1_scan");
            if (ser_latch && latch_at == 0) latch_at = i;
            if (row_en == 16'h0001) en1_cnt++;
        end
        chk("t1_latch_cycle", 32'(latch_at), 32'd34);
        chk("t1_row0_dwell", 32'(en1_cnt), 32'(DW));

        // 2: corner pixels of row 0, pulse in the FRAME cycle
        RedPixels[0] = 16'h8001;
        fd_cnt       = 0;
        fd_at        = 0;
        row0_bits    = '0;
        for (int i = 1; i <= FP; i++) begin
            frame_valid = (i == 1);
            step("t2_scan");
            frame_valid = 1'b0;
            if (ser_clk && i <= 33) row0_bits = {row0_bits[14:0], ser_red};
            if (frame_done) begin
                fd_cnt++;
                fd_at = i;
            end
        end
        chk("t2_row0_bits", 32'(row0_bits), 32'h8001);
        chk("t2_fd_count", 32'(fd_cnt), 32'd1);
        chk("t2_fd_cycle", 32'(fd_at), 32'(FP));

        // 3: checkerboard
        run_to(0, "t3_align");
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                RedPixels[r][c] = 1'((r + c) & 1);
                GrnPixels[r][c] = ~RedPixels[r][c];
            end
        end
        pulse_fv("t3_scan");
        run(FP - 1, "t3_scan");

        // 4: all-ones frame announced mid-frame at row 7
        run_to(1 + 7 * RP, "t4_align");
        RedPixels = '1;
        GrnPixels = '1;
        pulse_fv("t4_old");
        run(2 * FP, "t4_scan");

        // 5: reset mid-SHIFT of row 5, bit 9
        RedPixels[3] = 16'h5a5a;
        run_to(1 + 5 * RP + 9, "t5_align");
        reset = 1'b1;
        step("t5_reset");
        reset = 1'b0;
        run(FP + 50, "t5_restart");

        // 6: inputs wander without frame_valid
        for (int f = 0; f < 6; f++) begin
            for (int r = 0; r < 16; r++) begin
                RedPixels[r] = 16'($urandom);
                GrnPixels[r] = 16'($urandom);
            end
            run(FP / 3, "t6_hold");
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                for (int r = 0; r < 16; r++) begin
                    RedPixels[r] = 16'($urandom);
                    GrnPixels[r] = 16'($urandom);
                end
            end
            frame_valid = ($urandom_range(0, 99) == 0);
            reset       = ($urandom_range(0, 999) == 0);
            step("rand");
            frame_valid = 1'b0;
            reset       = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Row-scanning driver for the 16x16 red/green LED matrix board. It is the display-side consumer of the `RedPixels`/`GrnPixels` arrays produced by the game logic. It snapshots a complete frame at a frame boundary, then shifts each row serially into the board's column drivers. Each row is latched and enabled for a programmable dwell time before the driver moves to the next row.

## Interface
Parameters:
- `DWELL`, default 1000: cycles each row stays enabled; legal range 1 to 65535.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `RedPixels`, input, [15:0][15:0]: red frame, indexed `[row][col]`.
- `GrnPixels`, input, [15:0][15:0]: green frame, indexed `[row][col]`.
- `frame_valid`, input, 1: single-cycle pulse meaning a new frame is stable on the pixel inputs.
- `ser_red`, output, 1: serial red column data.
- `ser_grn`, output, 1: serial green column data.
- `ser_clk`, output, 1: column shift clock; drivers sample data on its rising edge.
- `ser_latch`, output, 1: one-cycle pulse that transfers the shifted row to the column outputs.
- `row_en`, output, 16: one-hot row enable, active-high; all zero while blanked.
- `frame_done`, output, 1: one-cycle pulse at the end of the row 15 display period.

## Operation
- Shadow registers `shadow_red` and `shadow_grn` (256 bits each) hold the frame being displayed. The pixel inputs are never read mid-frame.
- `pending` flag:
  - Set by `frame_valid`.
  - Cleared when a capture occurs.
  - Reset value 1, so the first frame after reset is captured.
- States and transitions:
  - FRAME (1 cycle): if `pending` or `frame_valid`, load the shadows from the inputs and clear `pending`. Set row = 0 and bit = 0. Next state is SHIFT.
  - SHIFT (32 cycles): for bit k = 0..15, the shifted column is c = 15 − k.
    - Cycle 2k: `ser_red` = `shadow_red[row][c]`, `ser_grn` = `shadow_grn[row][c]`, `ser_clk` = 0.
    - Cycle 2k+1: data is held and `ser_clk` = 1.
    - After k = 15, go to LATCH.
  - LATCH (1 cycle): `ser_latch` = 1. Next state is DISPLAY; the dwell counter is loaded with `DWELL` − 1.
  - DISPLAY (`DWELL` cycles): `row_en` = 1 << row, and the counter decrements.
    - When the counter reaches 0 and row < 15: row increments and the next state is SHIFT.
    - When the counter reaches 0 and row = 15: `frame_done` = 1 in that last cycle, and the next state is FRAME.
- `row_en` is zero in FRAME, SHIFT and LATCH (blanking), which prevents ghosting.
- `ser_red` and `ser_grn` are 0 outside SHIFT.
- Counter widths: bit counter 5 bits (0..31), row counter 4 bits, dwell counter 16 bits.

## Timing
- Reset values: state FRAME, row 0, `pending` = 1, shadows all 0. Every output is 0: `ser_red`, `ser_grn`, `ser_clk`, `ser_latch`, `row_en`, `frame_done`.
- All outputs are registered. They change only on a `clk` edge, one cycle after the corresponding state entry.
- Row period is 33 + `DWELL` cycles. Frame period is 1 + 16·(33 + `DWELL`) cycles.
- Latency from the `frame_valid` pulse to its first visible row:
  - at most one full frame period, plus 34 cycles, plus 1 cycle of register latency;
  - 35 cycles when the pulse lands in the FRAME cycle.
- Boundary cases:
  - `frame_valid` in the FRAME cycle: captured in that same cycle; `pending` stays 0.
  - `frame_valid` during any other state: `pending` is set, and the displayed frame is unchanged until the next FRAME.
  - Multiple `frame_valid` pulses within one frame: only the inputs present at the next FRAME are captured.
  - Reset asserted in any state: the next cycle shows the reset values. SHIFT restarts at bit 0 of row 0 after one FRAME cycle.
  - `DWELL` = 1: DISPLAY lasts exactly 1 cycle.

## Test plan
All scenarios use `DWELL` = 4, giving a row period of 37 and a frame period of 593.

1. Reset with inputs all 0, then release reset:
   - all outputs 0 during reset;
   - after release, FRAME, then 16 `ser_clk` rising edges;
   - `ser_latch` pulses on cycle 34 after FRAME;
   - `row_en` = 16'h0001 for 4 cycles.
2. `RedPixels[0]` = 16'h8001, green all 0, `frame_valid` pulsed in the FRAME cycle:
   - `ser_red` sequence for row 0 is 1, 0×14, 1;
   - `ser_grn` stays 0;
   - `row_en` walks 0x0001 → 0x8000 across the frame;
   - `frame_done` pulses once on cycle 593.
3. Checkerboard (red `[r][c]` = (r+c)&1, green the inverse):
   - for every row, the sampled serial bits match the pattern;
   - `row_en` is 0 whenever `ser_clk` toggles.
4. `frame_valid` mid-frame at row 7, with new inputs all 1:
   - rows 7–15 still show the old frame;
   - the next frame shifts all 1s in both colours.
5. Reset asserted mid-SHIFT of row 5 (bit 9):
   - outputs 0 on the next cycle;
   - scan restarts at row 0 and the frame is re-captured.
6. Inputs change without `frame_valid` for 2 frames:
   - the serial output stays on the originally captured frame.
